rf_write_ctrl: RTL and testbench

Controller that owns the single write port of the processor register file. After reset, and on request, it sequences a full clear of all 2**A registers, because the register file's own reset only clears part of the array. In normal operation it arbitrates round-robin between N write requesters (ALU writeback, load writeback, ...) and drives WriteEn/Waddr/DataIn from registers.

---
 rtl/rf_ctrl_pkg.sv | 12 +
 rtl/rf_write_ctrl_rr_arbiter.sv | 31 +++
 rtl/rf_write_ctrl.sv | 106 ++++++++++
 tb/tb_rf_write_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and helpers for the register-file write controller.
// Optional build macro used by rf_write_ctrl: RF_ZERO_PROTECT_EN.
package rf_ctrl_pkg;

  typedef enum logic {CLEAR, RUN} rf_ctrl_state_t;

  // Round-robin pointer after a grant to idx among n requesters.
  function automatic int rr_next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rf_write_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

  always_comb begin
    logic found;
    int   j;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (en_i && !found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write-port owner: full clear after reset/ClearReq, then RR writeback.
// Build macro RF_ZERO_PROTECT_EN: accepted writes to address 0 are dropped.
module rf_write_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 4,
  parameter int N = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N-1:0]        ReqValid,
  input  logic [N-1:0][A-1:0] ReqAddr,
  input  logic [N-1:0][W-1:0] ReqData,
  output logic [N-1:0]        ReqReady,
  input  logic                ClearReq,
  output logic                Busy,
  output logic                WriteEn,
  output logic [A-1:0]        Waddr,
  output logic [W-1:0]        DataIn
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  rf_ctrl_state_t state_q;
  logic [A-1:0]   cnt_q;
  logic [PW-1:0]  ptr_q;
  logic           we_q;
  logic [A-1:0]   waddr_q;
  logic [W-1:0]   data_q;
  logic           clr_wr_q;

  logic           arb_en;
  logic [N-1:0]   gnt;
  logic [PW-1:0]  gidx;
  logic           hs;
  logic           wr_ok;
  logic [PW-1:0]  ptr_d;

  assign arb_en = !Reset && (state_q == RUN) && !ClearReq;

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req_i (ReqValid),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign hs    = |(gnt & ReqValid);
  assign ptr_d = PW'(rr_next_ptr(int'(gidx), N));

`ifdef RF_ZERO_PROTECT_EN
  assign wr_ok = (ReqAddr[gidx] != '0);
`else
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      ptr_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      data_q   <= '0;
      clr_wr_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          // ClearReq is deliberately not looked at here: a running clear never restarts.
          we_q     <= 1'b1;
          waddr_q  <= cnt_q;
          data_q   <= '0;
          clr_wr_q <= 1'b1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == {A{1'b1}}) state_q <= RUN;
        end
        RUN: begin
          clr_wr_q <= 1'b0;
          if (ClearReq) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            we_q    <= 1'b0;
          end else if (hs) begin
            we_q    <= wr_ok;
            waddr_q <= ReqAddr[gidx];
            data_q  <= ReqData[gidx];
            ptr_q   <= ptr_d;
          end else begin
            we_q    <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign ReqReady = gnt;
  // Busy also spans the final clear write, which lands in the first RUN cycle.
  assign Busy     = Reset || (state_q == CLEAR) || clr_wr_q;
  assign WriteEn  = we_q;
  assign Waddr    = waddr_q;
  assign DataIn   = data_q;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed bench for rf_write_ctrl (W=8, A=4, N=2); honours RF_ZERO_PROTECT_EN.
module tb_rf_write_ctrl;

  localparam int W = 8;
  localparam int A = 4;
  localparam int N = 2;

  logic                Clk = 1'b0;
  logic                Reset;
  logic [N-1:0]        ReqValid;
  logic [N-1:0][A-1:0] ReqAddr;
  logic [N-1:0][W-1:0] ReqData;
  logic [N-1:0]        ReqReady;
  logic                ClearReq;
  logic                Busy;
  logic                WriteEn;
  logic [A-1:0]        Waddr;
  logic [W-1:0]        DataIn;

  int n_chk  = 0;
  int n_fail = 0;

  rf_write_ctrl #(.W(W), .A(A), .N(N)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqAddr  (ReqAddr),
    .ReqData  (ReqData),
    .ReqReady (ReqReady),
    .ClearReq (ClearReq),
    .Busy     (Busy),
    .WriteEn  (WriteEn),
    .Waddr    (Waddr),
    .DataIn   (DataIn)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Entered in the cycle just before the first clear write; checks all 16 writes.
  task automatic run_clear(input int pulse_at);
    for (int i = 0; i < 16; i++) begin
      tick();
      ClearReq = 1'b0;
      check("clr_we",   WriteEn, 1);
      check("clr_addr", Waddr,   i);
      check("clr_data", DataIn,  0);
      check("clr_busy", Busy,    1);
      if (i == pulse_at) ClearReq = 1'b1;
    end
    ClearReq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset    = 1'b1;
    ReqValid = 2'b11;
    ReqAddr  = '0;
    ReqData  = '0;
    ClearReq = 1'b0;
    repeat (3) tick();
    check("rst_we",    WriteEn,  0);
    check("rst_addr",  Waddr,    0);
    check("rst_data",  DataIn,   0);
    check("rst_busy",  Busy,     1);
    check("rst_ready", ReqReady, 0);
    ReqValid = 2'b00;
    Reset    = 1'b0;
    #1;
    check("pre_clr_we",   WriteEn, 0);
    check("pre_clr_busy", Busy,    1);
    run_clear(-1);
    tick();
    check("post_clr_busy", Busy,    0);
    check("post_clr_we",   WriteEn, 0);

    // Round-robin: both requesting, grants alternate 0,1,0,1.
    ReqAddr[0] = 4'd3; ReqData[0] = 8'hAA;
    ReqAddr[1] = 4'd5; ReqData[1] = 8'h55;
    ReqValid   = 2'b11;
    #1;
    check("rr_ready0", ReqReady, 2'b01);
    for (int g = 0; g < 4; g++) begin
      tick();
      check("rr_we",   WriteEn, 1);
      check("rr_addr", Waddr,   (g % 2 == 0) ? 3 : 5);
      check("rr_data", DataIn,  (g % 2 == 0) ? 8'hAA : 8'h55);
      check("rr_ready", ReqReady, (g % 2 == 0) ? 2'b10 : 2'b01);
    end
    ReqValid = 2'b00;
    tick();
    check("idle_we",   WriteEn, 0);
    check("idle_addr", Waddr,   5);
    check("idle_data", DataIn,  8'h55);

    // Pointer is 0; lone requester 1 is still found by the circular search.
    ReqValid = 2'b10;
    #1;
    check("lone1_ready", ReqReady, 2'b10);
    tick();
    check("lone1_addr", Waddr, 5);
    ReqValid = 2'b01;
    #1;
    check("lone0_ready", ReqReady, 2'b01);
    tick();
    ReqValid = 2'b00;
    check("lone0_addr", Waddr, 3);

    // ClearReq beats a simultaneous request; request lands after the clear.
    ReqValid = 2'b01;
    ClearReq = 1'b1;
    #1;
    check("cr_ready", ReqReady, 2'b00);
    tick();
    ClearReq = 1'b0;
    #1;
    check("cr_no_write", WriteEn,  0);
    check("cr_busy",     Busy,     1);
    check("cr_ready_clr", ReqReady, 2'b00);
    run_clear(-1);
    check("cr_first_run_ready", ReqReady, 2'b01);
    tick();
    ReqValid = 2'b00;
    check("cr_req_we",   WriteEn, 1);
    check("cr_req_addr", Waddr,   3);
    check("cr_req_data", DataIn,  8'hAA);

    // Reset at clear address 7 restarts the whole sequence.
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mid_addr7", Waddr, 7);
    Reset = 1'b1;
    tick();
    check("mid_rst_we",   WriteEn, 0);
    check("mid_rst_addr", Waddr,   0);
    check("mid_rst_busy", Busy,    1);
    Reset = 1'b0;
    run_clear(-1);
    tick();
    check("mid_post_busy", Busy, 0);

    // ClearReq at clear address 10 is ignored.
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    run_clear(10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ign_we",   WriteEn, 0);
      check("ign_busy", Busy,    0);
    end

    // Address 0 handling.
    ReqAddr[0] = 4'd0; ReqData[0] = 8'hFF;
    ReqValid   = 2'b01;
    #1;
    check("z_ready", ReqReady, 2'b01);
    tick();
`ifdef RF_ZERO_PROTECT_EN
    check("z_we_blocked", WriteEn, 0);
`else
    check("z_we",   WriteEn, 1);
    check("z_addr", Waddr,   0);
    check("z_data", DataIn,  8'hFF);
`endif
    ReqAddr[0] = 4'd1; ReqData[0] = 8'h11;
    #1;
    check("z1_ready", ReqReady, 2'b01);
    tick();
    ReqValid = 2'b00;
    check("z1_we",   WriteEn, 1);
    check("z1_addr", Waddr,   1);
    check("z1_data", DataIn,  8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
